gpsrx_capture: RTL and testbench

Parametrised successor to the gpsreceiver2 front-end input path: captures 1/2/4/8-bit GPS front-end samples and packs them into 32-bit words in an on-chip buffer. The front-end bit clock, sync and data lines are oversampled in the sys_clk domain. Software controls and monitors the block through CSR registers, reads the captured words over a Wishbone slave port, and receives an interrupt on completion. Supports one-shot and continuous (ring) capture modes.

---
 rtl/gpsrx_capture_if.sv | 26 ++
 rtl/gpsrx_capture.sv | 225 ++++++++++++++++++++++
 tb/tb_gpsrx_capture.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpsrx_capture_if.sv
// gpsrx_capture_if: CSR and Wishbone slave signals of the GPS capture block.
// master drives csr_a/csr_we/csr_di and wb_*_i; slave returns csr_do, wb_dat_o, wb_ack_o.
interface gpsrx_capture_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic [31:0] wb_adr_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output csr_a, csr_we, csr_di,
    output wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  csr_do, wb_dat_o, wb_ack_o
  );

  modport slave (
    input  csr_a, csr_we, csr_di,
    input  wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output csr_do, wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/gpsrx_capture.sv
// gpsrx_capture: oversampled GPS front-end capture, packs samples into 32-bit buffer words.
// Ports: sys_clk/sys_rst (sync, active-high), bus (CSR + Wishbone slave),
//   gps_rec_clk/sync/data (async front-end), irq (one-cycle completion pulse).
module gpsrx_capture #(
  parameter logic [3:0] csr_addr    = 4'h0,
  parameter int         SAMPLE_BITS = 2,
  parameter int         DEPTH_LOG2  = 9,
  parameter int         SYNC_STAGES = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  gpsrx_capture_if.slave  bus,
  input  logic            gps_rec_clk,
  input  logic            gps_rec_sync,
  input  logic            gps_rec_data,
  output logic            irq
);

  localparam int SB    = SAMPLE_BITS;
  localparam int SPW   = 32 / SB;
  localparam int SCW   = $clog2(SPW);
  localparam int D     = DEPTH_LOG2;
  localparam int DEPTH = 1 << D;

  localparam logic [D:0]     FULL = {1'b1, {D{1'b0}}};
  localparam logic [3:0]     SBC  = 4'(SB);
  localparam logic [SCW-1:0] LAST = SCW'(SPW - 1);
  localparam logic [D-1:0]   PMAX = {D{1'b1}};

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [SYNC_STAGES-1:0] clk_q;
  logic [SYNC_STAGES-1:0] syn_q;
  logic [SYNC_STAGES-1:0] dat_q;
  logic                   clk_d;
  logic                   bit_stb;
  logic                   sync_s;
  logic                   data_s;

  logic [1:0]     state;
  logic           mode;
  logic [D:0]     len;
  logic [D:0]     wordcnt;
  logic [D-1:0]   wr_ptr;
  logic [15:0]    framerr;
  logic           overflow;
  logic [3:0]     bitcnt;
  logic [SB-1:0]  sample;
  logic [SCW-1:0] scnt;
  logic [31:0]    word;
  logic [31:0]    mem [DEPTH];

  logic           bank_ok;
  logic           ctrl_wr;
  logic           len_wr;
  logic           start;
  logic           abort;
  logic           active;
  logic [3:0]     bc_n;
  logic [SB-1:0]  sm_n;
  logic           smp_ok;
  logic           fr_inc;
  logic [31:0]    wd_n;
  logic [D:0]     wc_n;
  logic           wr_en;
  logic [D:0]     len_val;
  logic [31:0]    rd_val;
  logic [D-1:0]   wb_idx;
  logic           wb_req;

  logic unused;
  assign unused = ^{bus.wb_adr_i[31:D+2], bus.wb_adr_i[1:0],
                    bus.csr_a[9:3], bus.wb_we_i};

  // Clock, sync and data travel through identical chains so a bit
  // strobe always sees the sync/data that were sampled alongside it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      clk_q <= '0;
      syn_q <= '0;
      dat_q <= '0;
      clk_d <= 1'b0;
    end else begin
      clk_q <= {clk_q[SYNC_STAGES-2:0], gps_rec_clk};
      syn_q <= {syn_q[SYNC_STAGES-2:0], gps_rec_sync};
      dat_q <= {dat_q[SYNC_STAGES-2:0], gps_rec_data};
      clk_d <= clk_q[SYNC_STAGES-1];
    end
  end

  assign bit_stb = clk_q[SYNC_STAGES-1] & ~clk_d;
  assign sync_s  = syn_q[SYNC_STAGES-1];
  assign data_s  = dat_q[SYNC_STAGES-1];

  assign bank_ok = bus.csr_a[13:10] == csr_addr;
  assign ctrl_wr = bus.csr_we & bank_ok & (bus.csr_a[2:0] == 3'd0);
  assign len_wr  = bus.csr_we & bank_ok & (bus.csr_a[2:0] == 3'd1);
  assign start   = ctrl_wr & bus.csr_di[0];
  assign abort   = ctrl_wr & bus.csr_di[1];
  assign active  = (state == ARMED) | (state == CAPTURE);

  assign len_val = (bus.csr_di == 32'd0 || bus.csr_di > 32'(DEPTH))
                 ? FULL : bus.csr_di[D:0];

  // Deserialiser: bitcnt==0 means "waiting for sync", which also
  // makes ARMED drop everything ahead of the first framed sample.
  always_comb begin
    bc_n   = bitcnt;
    sm_n   = sample;
    smp_ok = 1'b0;
    fr_inc = 1'b0;
    if (active && bit_stb) begin
      if (sync_s) begin
        bc_n   = 4'd1;
        sm_n   = SB'(data_s);
        smp_ok = SBC == 4'd1;
        fr_inc = (bitcnt != 4'd0) && (bitcnt != SBC);
      end else if (bitcnt != 4'd0 && bitcnt < SBC) begin
        bc_n   = bitcnt + 4'd1;
        sm_n   = SB'({sample, data_s});
        smp_ok = (bitcnt + 4'd1) == SBC;
      end
    end
  end

  assign wd_n  = 32'({word, sm_n});
  assign wc_n  = (wordcnt == FULL) ? FULL : wordcnt + 1'b1;
  assign wr_en = smp_ok & (scnt == LAST) & ~abort & ~sys_rst;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      mode     <= 1'b0;
      len      <= FULL;
      wordcnt  <= '0;
      wr_ptr   <= '0;
      framerr  <= '0;
      overflow <= 1'b0;
      bitcnt   <= '0;
      sample   <= '0;
      scnt     <= '0;
      word     <= '0;
      irq      <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (ctrl_wr) mode <= bus.csr_di[2];
      if (len_wr)  len  <= len_val;
      if (abort) begin
        state  <= IDLE;
        bitcnt <= '0;
        scnt   <= '0;
      end else if (start && (state == IDLE || state == DONE)) begin
        state    <= ARMED;
        wr_ptr   <= '0;
        wordcnt  <= '0;
        framerr  <= '0;
        overflow <= 1'b0;
        bitcnt   <= '0;
        scnt     <= '0;
      end else if (active) begin
        bitcnt <= bc_n;
        sample <= sm_n;
        if (fr_inc && framerr != 16'hFFFF)
          framerr <= framerr + 16'd1;
        if (state == ARMED && bit_stb && sync_s)
          state <= CAPTURE;
        if (smp_ok) begin
          word <= wd_n;
          scnt <= (scnt == LAST) ? '0 : scnt + 1'b1;
        end
        if (wr_en) begin
          wr_ptr  <= wr_ptr + 1'b1;
          wordcnt <= wc_n;
          if (mode && wr_ptr == PMAX)
            overflow <= 1'b1;
          if (!mode && wc_n == len) begin
            state <= DONE;
            irq   <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= wd_n;
  end

  always_comb begin
    rd_val = '0;
    case (bus.csr_a[2:0])
      3'd0:    rd_val = {29'b0, mode, 2'b0};
      3'd1:    rd_val = 32'(len);
      3'd2:    rd_val = {29'b0, overflow, state == DONE, active};
      3'd3:    rd_val = 32'(wordcnt);
      3'd4:    rd_val = {16'b0, framerr};
      3'd5:    rd_val = 32'(wr_ptr);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) bus.csr_do <= '0;
    else         bus.csr_do <= bank_ok ? rd_val : 32'd0;
  end

  assign wb_idx = bus.wb_adr_i[D+1:2];
  // ~ack in the request forces a dead cycle between back-to-back acks.
  assign wb_req = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_ack_o;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.wb_ack_o <= 1'b0;
      bus.wb_dat_o <= '0;
    end else begin
      bus.wb_ack_o <= wb_req;
      if (wb_req)
        bus.wb_dat_o <= (wr_en && wr_ptr == wb_idx) ? wd_n : mem[wb_idx];
    end
  end

endmodule

// File: tb/tb_gpsrx_capture.sv
// tb_gpsrx_capture: self-checking bench for gpsrx_capture (2-bit samples, 4-word buffer).
// CSR vector table plus scoreboarded capture sequences read back over Wishbone.
module tb_gpsrx_capture;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic gps_clk = 1'b0;
  logic gps_sync = 1'b0;
  logic gps_data = 1'b0;
  logic irq;

  gpsrx_capture_if bus();

  gpsrx_capture #(
    .csr_addr(4'h0),
    .SAMPLE_BITS(2),
    .DEPTH_LOG2(2),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus),
    .gps_rec_clk(gps_clk),
    .gps_rec_sync(gps_sync),
    .gps_rec_data(gps_data),
    .irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int irq_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mw;
  int mn;

  always @(posedge sys_clk) if (irq) irq_cnt++;

  typedef struct {
    bit          we;
    logic [13:0] a;
    logic [31:0] di;
    logic [13:0] ra;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    bus.csr_a  = a;
    bus.csr_di = d;
    bus.csr_we = 1'b1;
    @(negedge sys_clk);
    bus.csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [13:0] a, output logic [31:0] d);
    @(negedge sys_clk);
    bus.csr_a  = a;
    bus.csr_we = 1'b0;
    @(negedge sys_clk);
    d = bus.csr_do;
  endtask

  task automatic csr_check(input string nm, input logic [13:0] a,
                           input logic [31:0] exp);
    logic [31:0] d;
    csr_read(a, d);
    check(nm, d, exp);
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input logic we,
                         output logic [31:0] d, output int lat);
    @(negedge sys_clk);
    bus.wb_adr_i = adr;
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    lat = 0;
    do begin
      @(negedge sys_clk);
      lat++;
    end while (!bus.wb_ack_o && lat < 8);
    if (!bus.wb_ack_o) lat = -1;
    d = bus.wb_dat_o;
    @(negedge sys_clk);
    check("wb_ack_gap", 32'(bus.wb_ack_o), 32'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic sb_read(input string nm, input int idx,
                         output logic [31:0] d);
    int lat;
    wb_xfer(32'(idx * 4), 1'b0, d, lat);
    check("wb_lat", 32'(lat), 32'd1);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h expected <queue empty>", nm, d);
    end else begin
      logic [31:0] e;
      e = exp_q.pop_front();
      if (d !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, d, e);
      end
    end
  endtask

  task automatic send_bit(input logic s, input logic d);
    @(negedge sys_clk);
    gps_sync = s;
    gps_data = d;
    gps_clk  = 1'b0;
    repeat (3) @(negedge sys_clk);
    gps_clk = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mw = '0;
    mn = 0;
  endtask

  task automatic send_sample(input logic [1:0] v);
    send_bit(1'b1, v[1]);
    send_bit(1'b0, v[0]);
    mw = {mw[29:0], v};
    mn++;
    if (mn == 16) begin
      exp_q.push_back(mw);
      mn = 0;
    end
  endtask

  task automatic settle();
    repeat (8) @(negedge sys_clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_buf [4];
    logic [31:0] w;
    logic [1:0]  v;
    int lat;
    int base;

    vt[0]  = '{0, 14'h0000, 0, 14'h0000, 32'h0, "ctrl_rst"};
    vt[1]  = '{0, 14'h0001, 0, 14'h0001, 32'h4, "len_rst"};
    vt[2]  = '{0, 14'h0002, 0, 14'h0002, 32'h0, "status_rst"};
    vt[3]  = '{0, 14'h0003, 0, 14'h0003, 32'h0, "wordcnt_rst"};
    vt[4]  = '{0, 14'h0004, 0, 14'h0004, 32'h0, "framerr_rst"};
    vt[5]  = '{0, 14'h0005, 0, 14'h0005, 32'h0, "wrptr_rst"};
    vt[6]  = '{0, 14'h0006, 0, 14'h0006, 32'h0, "unmapped"};
    vt[7]  = '{0, 14'h0401, 0, 14'h0401, 32'h0, "bank_miss_rd"};
    vt[8]  = '{1, 14'h0001, 32'h0, 14'h0001, 32'h4, "len_clamp0"};
    vt[9]  = '{1, 14'h0001, 32'h3, 14'h0001, 32'h3, "len_3"};
    vt[10] = '{1, 14'h0001, 32'h5, 14'h0001, 32'h4, "len_clamp_hi"};
    vt[11] = '{1, 14'h0401, 32'h2, 14'h0001, 32'h4, "bank_miss_wr"};
    vt[12] = '{1, 14'h0001, 32'h80000001, 14'h0001, 32'h4, "len_clamp_big"};
    vt[13] = '{1, 14'h0001, 32'h2, 14'h0001, 32'h2, "len_2"};
    vt[14] = '{1, 14'h0000, 32'h3, 14'h0002, 32'h0, "start_abort"};

    bus.csr_a = '0; bus.csr_we = 0; bus.csr_di = '0;
    bus.wb_adr_i = '0; bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;

    check("rst_csr_do", bus.csr_do, 32'h0);
    check("rst_wb_dat", bus.wb_dat_o, 32'h0);
    check("rst_wb_ack", 32'(bus.wb_ack_o), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    foreach (vt[i]) begin
      if (vt[i].we) csr_write(vt[i].a, vt[i].di);
      csr_check(vt[i].name, vt[i].ra, vt[i].exp);
    end

    // one-shot, LEN=2, repeating 00,01,10,11
    model_reset();
    base = irq_cnt;
    csr_write(14'h0, 32'h1);
    for (int i = 0; i < 32; i++) send_sample(2'(i % 4));
    settle();
    check("t1_irq", 32'(irq_cnt - base), 32'd1);
    csr_check("t1_status", 14'h2, 32'h2);
    csr_check("t1_wordcnt", 14'h3, 32'h2);
    csr_check("t1_wrptr", 14'h5, 32'h2);
    sb_read("t1_buf0", 0, d);
    sb_read("t1_buf1", 1, d);

    // Wishbone read/write of byte address 0x4
    wb_xfer(32'h4, 1'b0, d, lat);
    check("t6_lat", 32'(lat), 32'd1);
    check("t6_data", d, 32'h1B1B1B1B);
    wb_xfer(32'h4, 1'b1, d, lat);
    check("t6_wr_lat", 32'(lat), 32'd1);
    wb_xfer(32'h4, 1'b0, d, lat);
    check("t6_after_wr", d, 32'h1B1B1B1B);

    // leading unframed bits discarded while ARMED
    model_reset();
    base = irq_cnt;
    csr_write(14'h1, 32'h1);
    csr_write(14'h0, 32'h1);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) send_sample(2'b11);
    settle();
    check("t2_irq", 32'(irq_cnt - base), 32'd1);
    csr_check("t2_wordcnt", 14'h3, 32'h1);
    csr_check("t2_framerr", 14'h4, 32'h0);
    sb_read("t2_buf0", 0, d);
    check("t2_const", d, 32'hFFFFFFFF);

    // three truncated samples
    model_reset();
    csr_write(14'h0, 32'h1);
    for (int i = 0; i < 16; i++) begin
      send_sample(2'((i * 3 + 1) % 4));
      if (i == 2 || i == 5 || i == 9) send_bit(1'b1, 1'b1);
    end
    settle();
    csr_check("t3_framerr", 14'h4, 32'h3);
    csr_check("t3_status", 14'h2, 32'h2);
    sb_read("t3_buf0", 0, d);
    check("t3_const", d, 32'h4E4E4E4E);

    // continuous, 6 words into a 4-word ring
    model_reset();
    base = irq_cnt;
    csr_write(14'h0, 32'h5);
    csr_check("t4_ctrl", 14'h0, 32'h4);
    for (int wi = 0; wi < 6; wi++) begin
      w = '0;
      for (int s = 0; s < 16; s++) begin
        v = 2'($urandom_range(0, 3));
        w = {w[29:0], v};
        send_sample(v);
      end
      exp_buf[wi % 4] = w;
    end
    settle();
    check("t4_irq", 32'(irq_cnt - base), 32'd0);
    csr_check("t4_wrptr", 14'h5, 32'h2);
    csr_check("t4_status", 14'h2, 32'h5);
    csr_check("t4_wordcnt", 14'h3, 32'h4);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_buf[i]);
    for (int i = 0; i < 4; i++) sb_read("t4_buf", i, d);
    csr_write(14'h0, 32'h2);
    csr_check("t4_abort_status", 14'h2, 32'h4);

    // abort after 1.5 words
    model_reset();
    base = irq_cnt;
    csr_write(14'h1, 32'h4);
    csr_write(14'h0, 32'h1);
    for (int i = 0; i < 24; i++) send_sample(2'b01);
    settle();
    csr_check("t5_mid_wordcnt", 14'h3, 32'h1);
    csr_check("t5_mid_status", 14'h2, 32'h1);
    csr_write(14'h0, 32'h2);
    settle();
    csr_check("t5_status", 14'h2, 32'h0);
    csr_check("t5_wordcnt", 14'h3, 32'h1);
    check("t5_irq", 32'(irq_cnt - base), 32'd0);
    csr_write(14'h0, 32'h1);
    csr_check("t5_restart_wc", 14'h3, 32'h0);
    csr_check("t5_restart_st", 14'h2, 32'h1);

    // reset in the middle of a capture
    for (int i = 0; i < 20; i++) send_sample(2'b10);
    settle();
    csr_write(14'h1, 32'h3);
    @(negedge sys_clk);
    bus.csr_a = 14'h2;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("rst2_csr_do", bus.csr_do, 32'h0);
    csr_check("rst2_status", 14'h2, 32'h0);
    csr_check("rst2_wordcnt", 14'h3, 32'h0);
    csr_check("rst2_len", 14'h1, 32'h4);
    csr_check("rst2_wrptr", 14'h5, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
